// File: rtl/dplca_txop_select.sv
// DPLCA TXOP ID selection: scans the live claim table for a free TXOP ID,
// advertises a SOFT claim on it, and promotes it to HARD after enough
// table-ageing events pass without another node claiming the same ID.
module dplca_txop_select (
  input  logic         clk,
  input  logic         reset,
  input  logic         dplca_en,
  input  logic         dplca_new_age,
  input  logic         dplca_conflict,
  input  logic [511:0] txop_claim_table_unpacked,
  input  logic [7:0]   dplca_max_id,
  input  logic [15:0]  soft_claim_cycles,
  output logic [7:0]   local_nodeID,
  output logic [1:0]   dplca_txop_claim,
  output logic         claim_valid,
  output logic [2:0]   select_state
);

  localparam logic [1:0] CLAIM_SOFT = 2'b00;
  localparam logic [1:0] CLAIM_HARD = 2'b01;
  localparam logic [1:0] CLAIM_NONE = 2'b10;
  localparam logic [7:0] ID_NONE    = 8'hFF;

  typedef enum logic [2:0] {
    DISABLED   = 3'd0,
    WAIT_TABLE = 3'd1,
    SCAN       = 3'd2,
    SOFT_CLAIM = 3'd3,
    HARD_CLAIM = 3'd4,
    NO_FREE    = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  idx_reg, idx_next;
  logic [15:0] age_reg, age_next;
  logic [7:0]  id_reg, id_next;
  logic [1:0]  claim_reg, claim_next;
  logic        valid_reg, valid_next;

  logic [1:0]  table_entry [0:255];
  logic [15:0] age_inc;
  logic [15:0] promote_at;

  // Split the flat table into per-ID entries; the table is only ever read live.
  generate
    for (genvar gi = 0; gi < 256; gi++) begin : g_entry
      assign table_entry[gi] = txop_claim_table_unpacked[2*gi+1:2*gi];
    end
  endgenerate

  assign age_inc    = (age_reg == 16'hFFFF) ? age_reg : age_reg + 16'd1;
  assign promote_at = (soft_claim_cycles == 16'd0) ? 16'd1 : soft_claim_cycles;

  // Next-state logic; priority is enable, then conflict, then table ageing.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    age_next   = age_reg;
    id_next    = id_reg;
    if (!dplca_en) begin
      state_next = DISABLED;
      idx_next   = 8'd1;
      age_next   = 16'd0;
      id_next    = ID_NONE;
    end else begin
      case (state_reg)
        DISABLED: begin
          state_next = WAIT_TABLE;
          idx_next   = 8'd1;
          age_next   = 16'd0;
          id_next    = ID_NONE;
        end
        WAIT_TABLE: begin
          id_next = ID_NONE;
          if (dplca_new_age) begin
            state_next = SCAN;
            idx_next   = 8'd1;
          end
        end
        SCAN: begin
          if (dplca_new_age) begin
            idx_next = 8'd1;
          end else if (idx_reg > dplca_max_id) begin
            // max ID shrank under an active scan: nothing legal is left
            state_next = NO_FREE;
          end else if (table_entry[idx_reg] == CLAIM_NONE) begin
            state_next = SOFT_CLAIM;
            id_next    = idx_reg;
            age_next   = 16'd0;
          end else if (idx_reg == dplca_max_id) begin
            state_next = NO_FREE;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
        SOFT_CLAIM: begin
          if (dplca_conflict) begin
            state_next = WAIT_TABLE;
            id_next    = ID_NONE;
          end else if (dplca_new_age) begin
            if (table_entry[id_reg] == CLAIM_HARD) begin
              state_next = WAIT_TABLE;
              id_next    = ID_NONE;
            end else begin
              age_next = age_inc;
              if (age_inc >= promote_at) state_next = HARD_CLAIM;
            end
          end
        end
        HARD_CLAIM: begin
          if (dplca_conflict) begin
            state_next = WAIT_TABLE;
            id_next    = ID_NONE;
          end
        end
        NO_FREE: begin
          id_next = ID_NONE;
          if (dplca_new_age) begin
            state_next = SCAN;
            idx_next   = 8'd1;
          end
        end
        default: begin
          state_next = DISABLED;
          idx_next   = 8'd1;
          age_next   = 16'd0;
          id_next    = ID_NONE;
        end
      endcase
    end
  end

  // Advertised claim follows the state being entered so it changes on the same edge.
  always_comb begin
    claim_next = CLAIM_NONE;
    valid_next = 1'b0;
    if (state_next == SOFT_CLAIM) begin
      claim_next = CLAIM_SOFT;
      valid_next = 1'b1;
    end else if (state_next == HARD_CLAIM) begin
      claim_next = CLAIM_HARD;
      valid_next = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DISABLED;
      idx_reg   <= 8'd1;
      age_reg   <= 16'd0;
      id_reg    <= ID_NONE;
      claim_reg <= CLAIM_NONE;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      age_reg   <= age_next;
      id_reg    <= id_next;
      claim_reg <= claim_next;
      valid_reg <= valid_next;
    end
  end

  assign local_nodeID     = id_reg;
  assign dplca_txop_claim = claim_reg;
  assign claim_valid      = valid_reg;
  assign select_state     = state_reg;

endmodule

// File: tb/tb_dplca_txop_select.sv
// Self-checking bench for dplca_txop_select: directed scenarios followed by
// randomized tables checked against a first-free-slot / pulse-count model.
module tb_dplca_txop_select;

  localparam logic [2:0] S_DIS  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_SOFT = 3'd3;
  localparam logic [2:0] S_HARD = 3'd4;
  localparam logic [2:0] S_NOFR = 3'd5;
  localparam logic [1:0] C_SOFT = 2'b00;
  localparam logic [1:0] C_HARD = 2'b01;
  localparam logic [1:0] C_NONE = 2'b10;
  localparam logic [1:0] C_OCC  = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         dplca_en = 1'b0;
  logic         dplca_new_age = 1'b0;
  logic         dplca_conflict = 1'b0;
  logic [511:0] tbl = '0;
  logic [7:0]   dplca_max_id = 8'd10;
  logic [15:0]  soft_claim_cycles = 16'd1;
  logic [7:0]   local_nodeID;
  logic [1:0]   dplca_txop_claim;
  logic         claim_valid;
  logic [2:0]   select_state;

  int n_assert = 0;
  int n_fail   = 0;

  dplca_txop_select dut (
    .clk                       (clk),
    .reset                     (reset),
    .dplca_en                  (dplca_en),
    .dplca_new_age             (dplca_new_age),
    .dplca_conflict            (dplca_conflict),
    .txop_claim_table_unpacked (tbl),
    .dplca_max_id              (dplca_max_id),
    .soft_claim_cycles         (soft_claim_cycles),
    .local_nodeID              (local_nodeID),
    .dplca_txop_claim          (dplca_txop_claim),
    .claim_valid               (claim_valid),
    .select_state              (select_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] es, input logic [7:0] eid,
                       input logic [1:0] ec, input logic ev);
    logic [13:0] obs, exp;
    obs = {select_state, local_nodeID, dplca_txop_claim, claim_valid};
    exp = {es, eid, ec, ev};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d id=%0h claim=%0b valid=%0b, expected state=%0d id=%0h claim=%0b valid=%0b",
             tag, select_state, local_nodeID, dplca_txop_claim, claim_valid, es, eid, ec, ev);
    end
    $display("check %s state=%0d id=%0h claim=%0b valid=%0b", tag, select_state, local_nodeID,
             dplca_txop_claim, claim_valid);
  endtask

  // Any state without a held ID advertises FF / NONE / invalid.
  task automatic chk_idle(input string tag, input logic [2:0] es);
    check(tag, es, 8'hFF, C_NONE, 1'b0);
  endtask

  task automatic chk_soft(input string tag, input logic [7:0] id);
    check(tag, S_SOFT, id, C_SOFT, 1'b1);
  endtask

  task automatic chk_hard(input string tag, input logic [7:0] id);
    check(tag, S_HARD, id, C_HARD, 1'b1);
  endtask

  task automatic set_e(input int k, input logic [1:0] v);
    tbl[2*k +: 2] = v;
  endtask

  // Reference: lowest free ID in 1..max, or 0 when the range is full.
  function automatic int first_free(input logic [511:0] t, input int max_id);
    for (int k = 1; k <= max_id; k++)
      if (t[2*k +: 2] == C_NONE) return k;
    return 0;
  endfunction

  task automatic pulse_age();
    dplca_new_age = 1'b1;
    tick();
    dplca_new_age = 1'b0;
  endtask

  // Start a scan from WAIT_TABLE/NO_FREE and check every cycle until it resolves.
  // restart_after > 0 re-pulses new_age after that many scan cycles.
  task automatic run_scan(input string tag, input int restart_after);
    int f, m;
    m = dplca_max_id;
    f = first_free(tbl, m);
    pulse_age();
    chk_idle({tag, "_enter"}, S_SCAN);
    if (restart_after > 0) begin
      for (int i = 0; i < restart_after; i++) begin
        tick();
        chk_idle({tag, "_prerestart"}, S_SCAN);
      end
      pulse_age();
      chk_idle({tag, "_restart"}, S_SCAN);
    end
    if (f != 0) begin
      for (int i = 1; i < f; i++) begin
        tick();
        chk_idle({tag, "_scan"}, S_SCAN);
      end
      tick();
      chk_soft({tag, "_claim"}, f[7:0]);
    end else begin
      for (int i = 1; i < m; i++) begin
        tick();
        chk_idle({tag, "_scan"}, S_SCAN);
      end
      tick();
      chk_idle({tag, "_nofree"}, S_NOFR);
    end
  endtask

  initial begin
    int f, m, need, r;
    logic [1:0] occ;

    // Reset state
    tick();
    chk_idle("reset", S_DIS);
    reset = 1'b0;
    dplca_en = 1'b1;
    tick();
    chk_idle("enable", S_WAIT);
    dplca_conflict = 1'b1;
    tick();
    dplca_conflict = 1'b0;
    chk_idle("wait_conflict_ignored", S_WAIT);

    // Entries 1..4 HARD, 5 free, max 10
    for (int k = 0; k < 256; k++) set_e(k, C_NONE);
    for (int k = 1; k <= 4; k++) set_e(k, C_HARD);
    dplca_max_id = 8'd10;
    soft_claim_cycles = 16'd3;
    run_scan("find5", 0);

    // Promotion after three ageing pulses, idle cycles in between
    pulse_age();
    chk_soft("age1", 8'd5);
    tick();
    chk_soft("age1_idle", 8'd5);
    pulse_age();
    chk_soft("age2", 8'd5);
    pulse_age();
    chk_hard("age3_promote", 8'd5);
    pulse_age();
    chk_hard("age4_stay_hard", 8'd5);
    dplca_conflict = 1'b1;
    tick();
    dplca_conflict = 1'b0;
    chk_idle("hard_conflict", S_WAIT);

    // Soft claim dropped when the table shows ID 5 as HARD
    run_scan("refind5", 0);
    set_e(5, C_HARD);
    pulse_age();
    chk_idle("soft_seen_hard", S_WAIT);

    // All of 1..10 occupied, then 7 frees up
    for (int k = 1; k <= 10; k++) set_e(k, (k % 3 == 0) ? C_OCC : ((k % 2 == 0) ? C_SOFT : C_HARD));
    run_scan("full", 0);
    dplca_conflict = 1'b1;
    tick();
    dplca_conflict = 1'b0;
    chk_idle("nofree_conflict_ignored", S_NOFR);
    set_e(7, C_NONE);
    run_scan("find7", 0);

    // Conflict beats new_age even when the pulse would promote
    soft_claim_cycles = 16'd2;
    pulse_age();
    chk_soft("age_pre_conflict", 8'd7);
    dplca_conflict = 1'b1;
    dplca_new_age = 1'b1;
    tick();
    dplca_conflict = 1'b0;
    dplca_new_age = 1'b0;
    chk_idle("conflict_wins", S_WAIT);
    run_scan("find7b", 2);
    dplca_en = 1'b0;
    dplca_conflict = 1'b1;
    tick();
    dplca_conflict = 1'b0;
    chk_idle("disable_wins", S_DIS);
    dplca_en = 1'b1;
    tick();
    chk_idle("reenable", S_WAIT);

    // Reset mid-scan at index 3
    for (int k = 1; k <= 5; k++) set_e(k, C_HARD);
    set_e(6, C_NONE);
    pulse_age();
    chk_idle("rscan_enter", S_SCAN);
    tick();
    tick();
    chk_idle("rscan_idx3", S_SCAN);
    reset = 1'b1;
    tick();
    chk_idle("reset_midscan", S_DIS);
    reset = 1'b0;
    tick();
    chk_idle("after_reset1", S_WAIT);

    // soft_claim_cycles=0 promotes on the first pulse; then reset in HARD
    soft_claim_cycles = 16'd0;
    run_scan("find6", 0);
    pulse_age();
    chk_hard("zero_cycles_promote", 8'd6);
    reset = 1'b1;
    tick();
    chk_idle("reset_hard", S_DIS);
    reset = 1'b0;
    tick();
    chk_idle("after_reset2", S_WAIT);
    tick();
    chk_idle("reset_no_residue", S_WAIT);

    // Randomized tables against the reference model
    for (int it = 0; it < 24; it++) begin
      m = $urandom_range(1, 20);
      dplca_max_id = m[7:0];
      for (int k = 0; k < 256; k++) begin
        r = $urandom_range(0, 9);
        occ = (r < 3) ? C_SOFT : ((r < 6) ? C_HARD : C_OCC);
        set_e(k, ((it % 4 != 3) && r == 9) ? C_NONE : occ);
      end
      set_e(0, C_NONE);
      soft_claim_cycles = 16'($urandom_range(0, 4));
      f = first_free(tbl, m);
      run_scan("rnd", (f > 3) ? $urandom_range(0, 2) : 0);
      if (f != 0) begin
        r = $urandom_range(0, 2);
        set_e(f, (r == 0) ? C_SOFT : ((r == 1) ? C_NONE : C_OCC));
        need = (soft_claim_cycles == 16'd0) ? 1 : int'(soft_claim_cycles);
        for (int p = 1; p < need; p++) begin
          pulse_age();
          chk_soft("rnd_age", f[7:0]);
        end
        pulse_age();
        chk_hard("rnd_promote", f[7:0]);
        dplca_conflict = 1'b1;
        tick();
        dplca_conflict = 1'b0;
        chk_idle("rnd_release", S_WAIT);
      end else begin
        dplca_en = 1'b0;
        tick();
        chk_idle("rnd_disable", S_DIS);
        dplca_en = 1'b1;
        tick();
        chk_idle("rnd_reenable", S_WAIT);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dplca_txop_select.md
DPLCA_TXOP_SELECT -- requirements
Module: dplca_txop_select

Interface
REQ-001 clk  input  1  block clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 dplca_en  input  1  DPLCA enable; 0 forces state DISABLED.
REQ-004 dplca_new_age  input  1  one-clk pulse; claim table has just been aged/refreshed.
REQ-005 dplca_conflict  input  1  one-clk pulse; another node is using local_nodeID.
REQ-006 txop_claim_table_unpacked  input  512  entry k = bits [2k+1:2k]; SOFT=2'b00, HARD=2'b01, NONE=2'b10, 2'b11 is treated as occupied.
REQ-007 dplca_max_id  input  8  highest TXOP ID scanned; legal range 1..255.
REQ-008 soft_claim_cycles  input  16  dplca_new_age pulses held in SOFT before promotion to HARD; 0 is treated as 1.
REQ-009 local_nodeID  output  8  selected TXOP ID; 8'hFF when none is held.
REQ-010 dplca_txop_claim  output  2  claim advertised for local_nodeID: SOFT, HARD or NONE.
REQ-011 claim_valid  output  1  1 only in SOFT_CLAIM or HARD_CLAIM.
REQ-012 select_state  output  3  DISABLED=0, WAIT_TABLE=1, SCAN=2, SOFT_CLAIM=3, HARD_CLAIM=4, NO_FREE=5.

Function
REQ-013 All outputs and internal state shall be registered; there is no combinational input-to-output path.
REQ-014 Event priority, highest first: reset, then dplca_en==0, then dplca_conflict, then dplca_new_age.
REQ-015 DISABLED: local_nodeID=8'hFF, dplca_txop_claim=NONE, claim_valid=0, scan index=1, age count=0; dplca_en==1 moves to WAIT_TABLE on the next edge.
REQ-016 WAIT_TABLE: outputs as in DISABLED; dplca_new_age moves to SCAN with scan index=1.
REQ-017 SCAN: one entry examined per clk, starting at index 1; entry 0 (coordinator) is never selected.
REQ-018 SCAN: if the entry at the scan index is NONE, local_nodeID=index, age count=0, move to SOFT_CLAIM; the entry at index k is therefore claimed on the k-th edge after SCAN entry.
REQ-019 SCAN: if the entry is not NONE and index==dplca_max_id, move to NO_FREE; otherwise increment the index.
REQ-020 SCAN: the index shall never exceed dplca_max_id or wrap past 255.
REQ-021 SCAN: dplca_new_age during SCAN restarts the scan at index 1.
REQ-022 SOFT_CLAIM: dplca_txop_claim=SOFT, claim_valid=1.
REQ-023 SOFT_CLAIM: dplca_conflict releases the claim and moves to WAIT_TABLE.
REQ-024 SOFT_CLAIM on dplca_new_age: if table[local_nodeID]==HARD, treat it as a conflict and move to WAIT_TABLE.
REQ-025 SOFT_CLAIM on dplca_new_age otherwise: increment the age count; when the incremented count >= max(soft_claim_cycles,1), move to HARD_CLAIM.
REQ-026 The age count is 16-bit and saturates at 16'hFFFF.
REQ-027 HARD_CLAIM: dplca_txop_claim=HARD, claim_valid=1; dplca_new_age has no effect; dplca_conflict moves to WAIT_TABLE.
REQ-028 NO_FREE: local_nodeID=8'hFF, dplca_txop_claim=NONE, claim_valid=0; dplca_new_age moves to SCAN with index=1.
REQ-029 Leaving SOFT_CLAIM or HARD_CLAIM for any reason sets local_nodeID=8'hFF, dplca_txop_claim=NONE and claim_valid=0 on the same edge.
REQ-030 A dplca_conflict pulse in DISABLED, WAIT_TABLE, SCAN or NO_FREE is ignored.
REQ-031 The table input is sampled live each clk; the block stores no copy of it.

Reset
REQ-032 With reset==1 at a rising edge, the block enters DISABLED with the REQ-015 values, regardless of state or other inputs.
REQ-033 Reset asserted mid-SCAN or mid-claim abandons the operation; no partial claim persists.
REQ-034 Before the first reset edge, output values are undefined; the bench checks outputs only after reset.

Verification
REQ-035 Table with entries 1..4=HARD and 5=NONE, dplca_max_id=10, one dplca_new_age -> SCAN for 5 clk, then local_nodeID=5, dplca_txop_claim=SOFT, claim_valid=1.
REQ-036 soft_claim_cycles=3, claim held on ID 5, three dplca_new_age pulses with entry 5 not HARD -> HARD_CLAIM after the third pulse; HARD stays through further pulses.
REQ-037 Entries 1..10 occupied, dplca_max_id=10 -> NO_FREE after 10 clk with local_nodeID=8'hFF; set entry 7=NONE and pulse dplca_new_age -> SOFT_CLAIM on ID 7.
REQ-038 SOFT_CLAIM on ID 5, then dplca_new_age with entry 5=HARD -> WAIT_TABLE and dplca_txop_claim=NONE on that edge; dplca_conflict in HARD_CLAIM -> WAIT_TABLE.
REQ-039 Pulse dplca_conflict and dplca_new_age in the same clk during SOFT_CLAIM -> the conflict wins, giving WAIT_TABLE and no age increment; dplca_en=0 with dplca_conflict -> DISABLED.
REQ-040 reset pulsed mid-SCAN at index 3, and separately during HARD_CLAIM -> DISABLED on the next edge with all REQ-015 values; soft_claim_cycles=0 -> promotion after one dplca_new_age.
